// File: rtl/press_classifier.sv
// -----------------------------------------------------------------------------
// press_classifier
//
// Turns conditioned button activity into single-cycle gesture events:
// short press, long press and double press. Consumes the edge pulses produced
// by the upstream input conditioner (already synchronized and debounced) and
// feeds gesture events to the control logic.
//
// Parameters
//   LONG_T : hold length in cycles that makes a press long (>= 2)
//   DBL_T  : gap window in cycles after a short release in which a second
//            press turns the gesture into a double (>= 2)
//   CNT_W  : counter width, 2**CNT_W > max(LONG_T, DBL_T)
//
// Ports
//   clk          : single clock, shared with the conditioner
//   reset        : asynchronous reset, active-high
//   cond         : conditioned button level (sanity input only)
//   rising       : one-cycle pulse on the press edge
//   falling      : one-cycle pulse on the release edge
//   short_press  : one-cycle pulse, press released early, no second press
//   long_press   : one-cycle pulse when a press has been held LONG_T cycles
//   double_press : one-cycle pulse when a second press starts in the gap
//   held         : level, high while in PRESS1, LONGHELD or RELEASE
// -----------------------------------------------------------------------------
module press_classifier #(
  parameter int LONG_T = 1000,
  parameter int DBL_T  = 250,
  parameter int CNT_W  = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic cond,
  input  logic rising,
  input  logic falling,
  output logic short_press,
  output logic long_press,
  output logic double_press,
  output logic held
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PRESS1   = 3'd1,
    GAP      = 3'd2,
    LONGHELD = 3'd3,
    RELEASE  = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_T - 1);
  localparam logic [CNT_W-1:0] DBL_LAST  = CNT_W'(DBL_T - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             short_q, short_d;
  logic             long_q,  long_d;
  logic             dbl_q,   dbl_d;
  logic             held_q,  held_d;

  // The FSM runs purely on edge pulses; the level is accepted but not used
  // to steer any decision.
  logic cond_unused;
  assign cond_unused = cond;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      short_q <= 1'b0;
      long_q  <= 1'b0;
      dbl_q   <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      short_q <= short_d;
      long_q  <= long_d;
      dbl_q   <= dbl_d;
      held_q  <= held_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    short_d = 1'b0;
    long_d  = 1'b0;
    dbl_d   = 1'b0;

    case (state_q)
      IDLE: begin
        // rising wins even if falling arrives in the same cycle
        if (rising) begin
          state_d = PRESS1;
          cnt_d   = '0;
        end
      end
      PRESS1: begin
        // a release on the threshold cycle still counts as short
        if (falling) begin
          state_d = GAP;
          cnt_d   = '0;
        end else if (cnt_q == LONG_LAST) begin
          long_d  = 1'b1;
          state_d = LONGHELD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      LONGHELD: begin
        if (falling) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      GAP: begin
        // a second press on the timeout cycle still makes a double
        if (rising) begin
          dbl_d   = 1'b1;
          state_d = RELEASE;
          cnt_d   = '0;
        end else if (cnt_q == DBL_LAST) begin
          short_d = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RELEASE: begin
        if (falling) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // held is derived from the next state so it lands on the same edge as state
  assign held_d = (state_d == PRESS1) || (state_d == LONGHELD) ||
                  (state_d == RELEASE);

  assign short_press  = short_q;
  assign long_press   = long_q;
  assign double_press = dbl_q;
  assign held         = held_q;

endmodule

// File: tb/tb_press_classifier.sv
module tb_press_classifier;

  localparam int LONG_T = 8;
  localparam int DBL_T  = 6;
  localparam int CNT_W  = 4;

  logic clk;
  logic reset;
  logic cond;
  logic rising;
  logic falling;
  logic short_press;
  logic long_press;
  logic double_press;
  logic held;

  int checks;
  int errors;

  press_classifier #(
    .LONG_T(LONG_T),
    .DBL_T (DBL_T),
    .CNT_W (CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .cond        (cond),
    .rising      (rising),
    .falling     (falling),
    .short_press (short_press),
    .long_press  (long_press),
    .double_press(double_press),
    .held        (held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected vectors are {short_press, long_press, double_press, held}
  task automatic chk(input string tag, input logic [3:0] exp);
    logic [3:0] obs;
    obs = {short_press, long_press, double_press, held};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One active edge with the given pulses sampled, then check just after it
  task automatic tick(input logic r, input logic f, input logic [3:0] exp,
                      input string tag);
    rising  = r;
    falling = f;
    cond    = r ? 1'b1 : (f ? 1'b0 : cond);
    @(posedge clk);
    #1;
    rising  = 1'b0;
    falling = 1'b0;
    chk(tag, exp);
  endtask

  task automatic idle_ticks(input int n, input logic [3:0] exp, input string tag);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, exp, tag);
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    reset   = 1'b1;
    cond    = 1'b0;
    rising  = 1'b0;
    falling = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("reset_state", 4'b0000);
    reset = 1'b0;

    // Short press: rising E0, falling E3, short after E9
    tick(1'b1, 1'b0, 4'b0001, "short_e0");
    idle_ticks(2, 4'b0001, "short_e1_e2");
    tick(1'b0, 1'b1, 4'b0000, "short_e3");
    idle_ticks(5, 4'b0000, "short_gap");
    tick(1'b0, 1'b0, 4'b1000, "short_e9");
    idle_ticks(2, 4'b0000, "short_after");

    // Long press: long after E8, release at E20 emits nothing
    tick(1'b1, 1'b0, 4'b0001, "long_e0");
    idle_ticks(7, 4'b0001, "long_hold");
    tick(1'b0, 1'b0, 4'b0101, "long_e8");
    idle_ticks(11, 4'b0001, "longheld");
    tick(1'b0, 1'b1, 4'b0000, "long_e20");
    idle_ticks(8, 4'b0000, "long_after");

    // Release exactly at the long threshold: short path, GAP then short
    tick(1'b1, 1'b0, 4'b0001, "edge_long_e0");
    idle_ticks(7, 4'b0001, "edge_long_hold");
    tick(1'b0, 1'b1, 4'b0000, "edge_long_e8");
    idle_ticks(5, 4'b0000, "edge_long_gap");
    tick(1'b0, 1'b0, 4'b1000, "edge_long_short");
    tick(1'b0, 1'b0, 4'b0000, "edge_long_idle");

    // Double press inside the window
    tick(1'b1, 1'b0, 4'b0001, "dbl_e0");
    tick(1'b0, 1'b0, 4'b0001, "dbl_e1");
    tick(1'b0, 1'b1, 4'b0000, "dbl_e2");
    idle_ticks(2, 4'b0000, "dbl_gap");
    tick(1'b1, 1'b0, 4'b0011, "dbl_e5");
    idle_ticks(24, 4'b0001, "dbl_release");
    tick(1'b0, 1'b1, 4'b0000, "dbl_e30");
    idle_ticks(8, 4'b0000, "dbl_after");

    // Second press on the last gap cycle still wins as a double
    tick(1'b1, 1'b0, 4'b0001, "dbl_edge_e0");
    tick(1'b0, 1'b0, 4'b0001, "dbl_edge_e1");
    tick(1'b0, 1'b1, 4'b0000, "dbl_edge_e2");
    idle_ticks(5, 4'b0000, "dbl_edge_gap");
    tick(1'b1, 1'b0, 4'b0011, "dbl_edge_e8");
    tick(1'b0, 1'b1, 4'b0000, "dbl_edge_rel");
    idle_ticks(8, 4'b0000, "dbl_edge_after");

    // Spurious rising in PRESS1 is ignored
    tick(1'b1, 1'b0, 4'b0001, "spur_e0");
    idle_ticks(3, 4'b0001, "spur_e1_e3");
    tick(1'b1, 1'b0, 4'b0001, "spur_e4");
    idle_ticks(3, 4'b0001, "spur_e5_e7");
    tick(1'b0, 1'b0, 4'b0101, "spur_e8");
    tick(1'b0, 1'b1, 4'b0000, "spur_rel");

    // Both pulses together: rising wins in IDLE, falling wins in PRESS1,
    // rising wins in GAP, falling wins in RELEASE
    tick(1'b1, 1'b1, 4'b0001, "both_idle");
    tick(1'b1, 1'b1, 4'b0000, "both_press1");
    tick(1'b1, 1'b1, 4'b0011, "both_gap");
    tick(1'b1, 1'b1, 4'b0000, "both_release");
    idle_ticks(8, 4'b0000, "both_after");

    // Back-to-back: long press, one idle cycle, then a short press
    tick(1'b1, 1'b0, 4'b0001, "b2b_long_e0");
    idle_ticks(7, 4'b0001, "b2b_long_hold");
    tick(1'b0, 1'b0, 4'b0101, "b2b_long_e8");
    tick(1'b0, 1'b1, 4'b0000, "b2b_long_rel");
    tick(1'b0, 1'b0, 4'b0000, "b2b_idle");
    tick(1'b1, 1'b0, 4'b0001, "b2b_short_e0");
    idle_ticks(2, 4'b0001, "b2b_short_hold");
    tick(1'b0, 1'b1, 4'b0000, "b2b_short_e3");
    idle_ticks(5, 4'b0000, "b2b_short_gap");
    tick(1'b0, 1'b0, 4'b1000, "b2b_short_e9");
    tick(1'b0, 1'b0, 4'b0000, "b2b_after");

    // Asynchronous reset mid-cycle during PRESS1 with cnt == 3
    tick(1'b1, 1'b0, 4'b0001, "rst_e0");
    idle_ticks(3, 4'b0001, "rst_hold");
    #2;
    reset = 1'b1;
    #1;
    chk("rst_async", 4'b0000);
    @(posedge clk);
    #1;
    chk("rst_held_low", 4'b0000);
    reset = 1'b0;
    tick(1'b0, 1'b1, 4'b0000, "rst_falling_ignored");
    idle_ticks(12, 4'b0000, "rst_quiet");

    // A fresh press after reset works normally
    tick(1'b1, 1'b0, 4'b0001, "post_rst_e0");
    idle_ticks(7, 4'b0001, "post_rst_hold");
    tick(1'b0, 1'b0, 4'b0101, "post_rst_e8");
    tick(1'b0, 1'b1, 4'b0000, "post_rst_rel");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
